// File: rtl/f0_pkg.sv
// Shared definitions for the layer-0 forward-pass engine: FSM state encoding,
// default geometry and the accumulator width helper.
package f0_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ACC   = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } f0_state_t;

    localparam int F0_N_IN  = 4;
    localparam int F0_N_OUT = 4;
    localparam int F0_DW    = 8;

    // Full-precision product plus enough headroom for N_IN terms, so the
    // running sum can never wrap.
    function automatic int acc_width(input int dw, input int n_in);
        return 2 * dw + $clog2(n_in);
    endfunction

endpackage

// File: rtl/f0_mac.sv
// Signed multiply-accumulate datapath with a saturating output stage.
// Optional build macro: F0_RELU_EN clamps negative results to zero.
module f0_mac import f0_pkg::*; #(
    parameter int N_IN = F0_N_IN,
    parameter int DW   = F0_DW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 acc_en_i,
    input  logic signed [DW-1:0] w_i,
    input  logic signed [DW-1:0] x_i,
    output logic signed [DW-1:0] y_o
);

    localparam int AW = acc_width(DW, N_IN);
    localparam logic signed [AW-1:0] Y_MAX = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0] Y_MIN = AW'(-(2 ** (DW - 1)));

    logic signed [2*DW-1:0] prod_w;
    logic signed [AW-1:0]   acc_reg;
    logic signed [AW-1:0]   acc_next;
    logic signed [DW-1:0]   sat_w;

    assign prod_w   = w_i * x_i;
    assign acc_next = acc_reg + AW'(prod_w);

    // Accumulator: clear has priority over accumulate; frozen when en_i is low.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_reg <= '0;
        end else if (en_i) begin
            if (clr_i) begin
                acc_reg <= '0;
            end else if (acc_en_i) begin
                acc_reg <= acc_next;
            end
        end
    end

    // Clamp the wide sum into the signed output range.
    always_comb begin
        sat_w = acc_reg[DW-1:0];
        if (acc_reg > Y_MAX) begin
            sat_w = Y_MAX[DW-1:0];
        end else if (acc_reg < Y_MIN) begin
            sat_w = Y_MIN[DW-1:0];
        end
    end

`ifdef F0_RELU_EN
    assign y_o = sat_w[DW-1] ? '0 : sat_w;
`else
    assign y_o = sat_w;
`endif

endmodule

// File: rtl/f0_layer.sv
// Layer-0 forward pass: walks the weight matrix against the activation vector
// in external synchronous-read memories and streams one saturated result per
// output neuron over valid/ready. Optional build macro: F0_RELU_EN (see f0_mac).
module f0_layer import f0_pkg::*; #(
    parameter int N_IN  = F0_N_IN,
    parameter int N_OUT = F0_N_OUT,
    parameter int DW    = F0_DW
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic                             f0_pass_i,
    output logic [$clog2(N_OUT*N_IN)-1:0]    w_addr_o,
    output logic [$clog2(N_IN)-1:0]          x_addr_o,
    input  logic signed [DW-1:0]             w_i,
    input  logic signed [DW-1:0]             x_i,
    output logic signed [DW-1:0]             y_o,
    output logic [$clog2(N_OUT)-1:0]         y_idx_o,
    output logic                             y_valid_o,
    input  logic                             y_ready_i,
    output logic                             f0_end_o
);

    localparam int IW = $clog2(N_IN);
    localparam int OW = $clog2(N_OUT);
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);
    localparam logic [IW-1:0] I_ONE  = IW'(1);
    localparam logic [OW-1:0] O_ONE  = OW'(1);

    f0_state_t     state_reg, state_next;
    logic [IW-1:0] i_idx_reg;
    logic [OW-1:0] o_idx_reg;
    logic          idx_clr;
    logic          i_inc;
    logic          o_adv;
    logic          acc_clr;
    logic          acc_en;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
        end else if (en_i) begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath control; dropping f0_pass_i mid-pass aborts
    // without touching the indices or the accumulator.
    always_comb begin
        state_next = state_reg;
        idx_clr    = 1'b0;
        i_inc      = 1'b0;
        o_adv      = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                idx_clr = 1'b1;
                acc_clr = 1'b1;
                if (f0_pass_i) state_next = FETCH;
            end
            FETCH: begin
                state_next = f0_pass_i ? ACC : IDLE;
            end
            ACC: begin
                if (!f0_pass_i) begin
                    state_next = IDLE;
                end else begin
                    acc_en = 1'b1;
                    if (i_idx_reg == I_LAST) begin
                        state_next = OUT;
                    end else begin
                        i_inc      = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            OUT: begin
                if (!f0_pass_i) begin
                    state_next = IDLE;
                end else if (y_ready_i) begin
                    if (o_idx_reg == O_LAST) begin
                        state_next = DONE;
                    end else begin
                        o_adv      = 1'b1;
                        acc_clr    = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                if (!f0_pass_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Input/output neuron index counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            i_idx_reg <= '0;
            o_idx_reg <= '0;
        end else if (en_i) begin
            if (idx_clr) begin
                i_idx_reg <= '0;
                o_idx_reg <= '0;
            end else if (o_adv) begin
                i_idx_reg <= '0;
                o_idx_reg <= o_idx_reg + O_ONE;
            end else if (i_inc) begin
                i_idx_reg <= i_idx_reg + I_ONE;
            end
        end
    end

    // Addresses depend only on registered indices so memory data survives a freeze.
    assign w_addr_o  = {o_idx_reg, i_idx_reg};
    assign x_addr_o  = i_idx_reg;
    assign y_idx_o   = o_idx_reg;
    assign y_valid_o = (state_reg == OUT);
    assign f0_end_o  = (state_reg == DONE);

    f0_mac #(
        .N_IN (N_IN),
        .DW   (DW)
    ) u_mac (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .clr_i    (acc_clr),
        .acc_en_i (acc_en),
        .w_i      (w_i),
        .x_i      (x_i),
        .y_o      (y_o)
    );

endmodule

// File: tb/tb_f0_layer.sv
// Directed self-checking bench for f0_layer with a synchronous-read memory model.
module tb_f0_layer;

    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int DW    = 8;

    logic                 clk_i     = 1'b0;
    logic                 rst_i     = 1'b1;
    logic                 en_i      = 1'b0;
    logic                 f0_pass_i = 1'b0;
    logic                 y_ready_i = 1'b0;
    logic [3:0]           w_addr_o;
    logic [1:0]           x_addr_o;
    logic signed [DW-1:0] w_i;
    logic signed [DW-1:0] x_i;
    logic signed [DW-1:0] y_o;
    logic [1:0]           y_idx_o;
    logic                 y_valid_o;
    logic                 f0_end_o;

    logic signed [DW-1:0] w_mem [N_OUT*N_IN];
    logic signed [DW-1:0] x_mem [N_IN];
    int    exp_y [N_OUT];
    int    n_chk  = 0;
    int    n_pass = 0;
    string cur    = "reset";

    f0_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .f0_pass_i (f0_pass_i),
        .w_addr_o  (w_addr_o),
        .x_addr_o  (x_addr_o),
        .w_i       (w_i),
        .x_i       (x_i),
        .y_o       (y_o),
        .y_idx_o   (y_idx_o),
        .y_valid_o (y_valid_o),
        .y_ready_i (y_ready_i),
        .f0_end_o  (f0_end_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous-read memories: data appears one cycle after the address.
    always @(posedge clk_i) begin
        w_i <= w_mem[w_addr_o];
        x_i <= x_mem[x_addr_o];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s.%s: got %0d expected %0d", cur, tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // mode 0: w=1; 1: w=127; 2: w=-128; 3: w=-1; 4: w=o+1.  x=127 for modes 1,2 else i+1.
    task automatic load(input int mode);
        int wv;
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) begin
                case (mode)
                    0:       wv = 1;
                    1:       wv = 127;
                    2:       wv = -128;
                    3:       wv = -1;
                    default: wv = o + 1;
                endcase
                w_mem[o*N_IN+i] = 8'(wv);
            end
        end
        for (int i = 0; i < N_IN; i++)
            x_mem[i] = (mode == 1 || mode == 2) ? 8'sd127 : 8'(i + 1);
    endtask

    task automatic set_exp(input int a, input int b, input int c, input int d);
        exp_y[0] = a; exp_y[1] = b; exp_y[2] = c; exp_y[3] = d;
    endtask

    // One pass starting from IDLE. Edge 0 samples f0_pass_i=1. Freeze windows are
    // 3 edges long starting at frz_a/frz_b; y_ready_i is low for bp_len edges from bp_at.
    task automatic run_pass(input string name, input int exp_first, input int exp_done,
                            input int exp_xfers, input int abort_at, input int frz_a,
                            input int frz_b, input int bp_at, input int bp_len);
        int xfers, done_at, first_v, y_prev, idx_prev;
        bit fa, fb, stall, v_prev;
        cur = name;
        xfers = 0; done_at = -1; first_v = -1;
        en_i = 1'b1; y_ready_i = 1'b1; f0_pass_i = 1'b1;
        tick();
        for (int n = 1; n <= 120; n++) begin
            fa    = (frz_a > 0) && (n >= frz_a) && (n < frz_a + 3);
            fb    = (frz_b > 0) && (n >= frz_b) && (n < frz_b + 3);
            stall = (bp_at > 0) && (n >= bp_at) && (n < bp_at + bp_len);
            en_i      = !(fa || fb);
            y_ready_i = !stall;
            if (n == abort_at) f0_pass_i = 1'b0;
            v_prev   = y_valid_o;
            y_prev   = int'(y_o);
            idx_prev = int'(y_idx_o);
            tick();
            if (v_prev && en_i && y_ready_i && n != abort_at) begin
                $display("%s xfer edge=%0d idx=%0d y=%0d", name, n, idx_prev, y_prev);
                check("y", y_prev, exp_y[xfers % N_OUT]);
                check("y_idx", idx_prev, xfers % N_OUT);
                xfers++;
            end
            if (y_valid_o && first_v < 0) first_v = n;
            if (fa) begin
                check("frzA_waddr", int'(w_addr_o), 0);
                check("frzA_valid", int'(y_valid_o), 0);
            end
            if (fb) begin
                check("frzB_valid", int'(y_valid_o), 1);
                check("frzB_y", int'(y_o), exp_y[0]);
                check("frzB_waddr", int'(w_addr_o), N_IN - 1);
                check("frzB_xaddr", int'(x_addr_o), N_IN - 1);
            end
            if (stall) begin
                check("bp_valid", int'(y_valid_o), 1);
                check("bp_y", int'(y_o), exp_y[1]);
                check("bp_idx", int'(y_idx_o), 1);
            end
            if (n == abort_at) begin
                check("abort_valid", int'(y_valid_o), 0);
                check("abort_end", int'(f0_end_o), 0);
                break;
            end
            if (f0_end_o) begin
                done_at = n;
                break;
            end
        end
        en_i = 1'b1; y_ready_i = 1'b1;
        check("first_valid_edge", first_v, exp_first);
        check("done_edge", done_at, exp_done);
        check("xfers", xfers, exp_xfers);
        if (abort_at > 0) begin
            tick();
            check("idle_waddr", int'(w_addr_o), 0);
            check("idle_end", int'(f0_end_o), 0);
        end else begin
            repeat (3) begin
                tick();
                check("end_hold", int'(f0_end_o), 1);
            end
            f0_pass_i = 1'b0;
            tick();
            check("end_drop", int'(f0_end_o), 0);
            check("idle_valid", int'(y_valid_o), 0);
            tick();
            check("idle_waddr", int'(w_addr_o), 0);
        end
    endtask

    initial begin
        int neg_sat, neg_ten;
`ifdef F0_RELU_EN
        neg_sat = 0;
        neg_ten = 0;
`else
        neg_sat = -128;
        neg_ten = -10;
`endif
        load(0);
        #2 rst_i = 1'b0;
        #1;
        check("rst_valid", int'(y_valid_o), 0);
        check("rst_end", int'(f0_end_o), 0);
        check("rst_y", int'(y_o), 0);
        check("rst_idx", int'(y_idx_o), 0);
        check("rst_waddr", int'(w_addr_o), 0);
        check("rst_xaddr", int'(x_addr_o), 0);
        tick();
        rst_i = 1'b1;
        en_i  = 1'b1;
        tick();

        load(0); set_exp(10, 10, 10, 10);
        run_pass("t1_basic", 8, 36, 4, 0, 0, 0, 0, 0);

        load(1); set_exp(127, 127, 127, 127);
        run_pass("t2_sat_pos", 8, 36, 4, 0, 0, 0, 0, 0);

        load(2); set_exp(neg_sat, neg_sat, neg_sat, neg_sat);
        run_pass("t2_sat_neg", 8, 36, 4, 0, 0, 0, 0, 0);

        load(3); set_exp(neg_ten, neg_ten, neg_ten, neg_ten);
        run_pass("t3_relu", 8, 36, 4, 0, 0, 0, 0, 0);

        load(4); set_exp(10, 20, 30, 40);
        run_pass("t4_backpressure", 8, 41, 4, 0, 0, 0, 18, 5);

        run_pass("t5_abort", 8, -1, 2, 20, 0, 0, 0, 0);
        run_pass("t5_restart", 8, 36, 4, 0, 0, 0, 0, 0);

        load(0); set_exp(10, 10, 10, 10);
        run_pass("t6_freeze", 11, 42, 4, 0, 2, 12, 0, 0);

        // Asynchronous reset while a result is pending.
        cur = "t7_async_rst";
        load(4); set_exp(10, 20, 30, 40);
        en_i = 1'b1; y_ready_i = 1'b0; f0_pass_i = 1'b1;
        repeat (9) tick();
        check("pre_valid", int'(y_valid_o), 1);
        check("pre_y", int'(y_o), 10);
        #2 rst_i = 1'b0;
        #1;
        check("rst_valid", int'(y_valid_o), 0);
        check("rst_y", int'(y_o), 0);
        check("rst_waddr", int'(w_addr_o), 0);
        f0_pass_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/f0_layer.md
# f0_layer

Forward-pass compute engine for layer 0. It runs when the pass sequencer asserts its f0-pass output and returns the end flag that the sequencer samples as its f0-end input. It walks an N_OUT × N_IN weight matrix against an N_IN activation vector held in external synchronous-read memories. Each output neuron is accumulated with signed multiply-accumulate, saturated, and handed downstream over a valid/ready port.

## Interface

Parameters:
- N_IN, 4: inputs per neuron (≥2, power of two)
- N_OUT, 4: output neurons (≥2, power of two)
- DW, 8: signed data width of weights, activations and outputs

Ports:
- clk_i, input, 1: clock
- rst_i, input, 1: reset, asynchronous, active-low
- en_i, input, 1: global enable; when low, all state is frozen
- f0_pass_i, input, 1: level input from the sequencer; high requests or continues the pass
- w_addr_o, output, clog2(N_OUT*N_IN): weight address {o_idx, i_idx}
- x_addr_o, output, clog2(N_IN): activation address i_idx
- w_i, input, DW: signed weight; valid one cycle after w_addr_o
- x_i, input, DW: signed activation; valid one cycle after x_addr_o
- y_o, output, DW: signed neuron result
- y_idx_o, output, clog2(N_OUT): neuron index of y_o
- y_valid_o, output, 1: y_o is valid
- y_ready_i, input, 1: downstream accepts y_o
- f0_end_o, output, 1: pass complete; held until f0_pass_i falls

## Operation

- States: IDLE, FETCH, ACC, OUT, DONE. Transitions occur only on clock edges with en_i=1.
- IDLE:
  - On f0_pass_i=1, go to FETCH.
  - Clear acc, o_idx and i_idx.
- FETCH:
  - Addresses are driven from the registered indices.
  - Next state is ACC.
- ACC:
  - acc <= acc + w_i*x_i.
  - If i_idx==N_IN-1, go to OUT. Otherwise i_idx++ and return to FETCH.
- OUT:
  - y_valid_o=1, y_idx_o=o_idx, y_o=sat(acc).
  - Stay in OUT until y_ready_i=1.
  - On handshake, if o_idx==N_OUT-1 go to DONE. Otherwise o_idx++, i_idx=0, acc=0, and go to FETCH.
- DONE:
  - f0_end_o=1.
  - Stay while f0_pass_i=1. Go to IDLE when it is 0.
- Abort: f0_pass_i=0 in FETCH, ACC or OUT sends the block to IDLE on the next enabled edge. y_valid_o drops and no f0_end_o is produced.
- Arithmetic:
  - Product is 2·DW signed.
  - acc is 2·DW+clog2(N_IN) bits signed, which cannot overflow.
  - sat() clamps to [−2^(DW−1), 2^(DW−1)−1].
- Addresses are functions of the registered indices only, so they are stable through ACC and while en_i=0. This keeps memory data valid across a freeze.

## Timing

- Reset values:
  - state=IDLE; acc, o_idx, i_idx = 0.
  - y_valid_o=0, f0_end_o=0, y_o=0, y_idx_o=0.
  - w_addr_o=0, x_addr_o=0.
- Call the edge that samples f0_pass_i=1 in IDLE edge 0.
- The first y_valid_o rises after edge 2·N_IN, i.e. edge 8 with the defaults.
- Each neuron costs 2·N_IN+1 enabled cycles when y_ready_i is held high.
- DONE is entered at edge N_OUT·(2·N_IN+1), i.e. edge 36 with the defaults. f0_end_o is registered high from that edge.
- Valid/ready rules:
  - y_o and y_idx_o are stable while y_valid_o=1 and y_ready_i=0.
  - A transfer happens on an edge where both are 1 and en_i=1.
- en_i=0 holds every register, including y_valid_o and f0_end_o. A y_ready_i pulse during a freeze is ignored.
- Simultaneous y_ready_i=1 and f0_pass_i=0 in OUT: abort wins and the transfer does not count.
- An asynchronous reset mid-pass returns the block to reset values immediately.

## Configuration

- F0_RELU_EN defined: y_o = max(0, sat(acc)).
- F0_RELU_EN undefined: y_o = sat(acc). Negative results pass through in two's complement.
- No other behaviour changes.

## Structure

- Shared package f0_pkg holds:
  - state enum: IDLE=3'd0, FETCH=3'd1, ACC=3'd2, OUT=3'd3, DONE=3'd4.
  - default N_IN, N_OUT, DW constants.
  - accumulator-width function.
- One sub-module, f0_mac:
  - Holds the signed multiply, the accumulator register with clear/enable, and the saturation/ReLU output stage.
  - The top level holds the FSM, index counters and handshake.

## Test plan

1. All w=1, x={1,2,3,4}, y_ready_i=1:
   - Four transfers, y_idx 0..3, each y_o=10.
   - f0_end_o rises at edge 36 and holds until f0_pass_i falls, then IDLE is reached.
2. Saturation, w=127, x=127 for every element:
   - acc=64516, so y_o=127.
   - With w=−128, x=127: y_o=−128 without F0_RELU_EN, 0 with it.
3. ReLU, w=−1, x={1,2,3,4}:
   - y_o=−10 (0xF6) without F0_RELU_EN.
   - y_o=0 with F0_RELU_EN.
4. Backpressure, y_ready_i low for 5 cycles at neuron 1:
   - y_valid_o, y_o and y_idx_o are held constant.
   - A single transfer occurs, and total completion is delayed by exactly 5 cycles.
5. Abort, f0_pass_i dropped during ACC of neuron 2:
   - IDLE next edge, y_valid_o=0, f0_end_o never asserted.
   - A restart then produces correct values from neuron 0.
6. Enable freeze, en_i low for 3 cycles in ACC and 3 cycles in OUT:
   - Addresses and outputs are held, and results are identical to test 1.
   - Completion shifts by 6 cycles.
